// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table and blank pattern.
// Glyphs are active-low, bit order GFEDCBA.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/seven_seg_scan_if.sv
// Host/display signal bundle for seven_seg_scan; master drives load/value/dp_mask/blank,
// slave (the driver) produces the display pins and frame_done.
interface seven_seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic                      blank;
    logic [6:0]                seg_n;
    logic                      dp_n;
    logic [NUM_DIGITS-1:0]     an_n;
    logic                      frame_done;

    modport master (
        output load, value, dp_mask, blank,
        input  seg_n, dp_n, an_n, frame_done
    );

    modport slave (
        input  load, value, dp_mask, blank,
        output seg_n, dp_n, an_n, frame_done
    );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph lookup (active-low GFEDCBA).
module seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    assign seg_o = GLYPH[nib_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous value update.
// Define SEVSEG_LZB_EN to blank leading zero digits (digit 0 always shown).
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned GUARD      = 16
) (
    input logic              clk,
    input logic              rst,
    seven_seg_scan_if.slave  bus
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    seg_t                    seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    logic                    div_wrap, idx_wrap, boundary;
    logic [NUM_DIGITS-1:0]   lzb;
    logic [3:0]              cur_nib;
    seg_t                    cur_glyph;

    assign div_wrap = (div_q == DIV_W'(SCAN_DIV - 1));
    assign idx_wrap = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign boundary = div_wrap & idx_wrap;
    assign cur_nib  = act_val_q[4*idx_q +: 4];

    seg_hex_decode u_dec (
        .nib_i (cur_nib),
        .seg_o (cur_glyph)
    );

    always_comb begin
        lzb = '0;
`ifdef SEVSEG_LZB_EN
        begin : lzb_scan
            logic run;
            run = 1'b1;
            for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
                run    = run & (act_val_q[4*i +: 4] == 4'h0) & ~act_dp_q[i];
                lzb[i] = run;
            end
        end
`endif
    end

    always_comb begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        idx_d = idx_q;
        if (div_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + 1'b1;
        end

        // A load in the boundary cycle lands in pending and active together so the
        // following boundary does not revert the display to an older value.
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_mask;
        end
        if (boundary) begin
            act_val_d = pend_val_d;
            act_dp_d  = pend_dp_d;
        end

        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        an_d  = '1;
        fd_d  = boundary;
        if ((32'(div_q) >= GUARD) && !bus.blank && !lzb[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = cur_glyph;
            dp_d        = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            an_q       <= '1;
            fd_q       <= 1'b0;
        end else begin
            div_q      <= div_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_q;
    assign bus.an_n       = an_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a cycle-level display model queues expected pins,
// a negedge monitor pops and compares them.
module tb_seven_seg_scan;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int GD = 2;
    localparam int FRAME = SD * ND;

    typedef struct {
        logic [6:0]    seg;
        logic          dp;
        logic [ND-1:0] an;
        logic          fd;
        int            n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    int            t = 0;
    logic [15:0]   latest_v = '0, shown_v = '0;
    logic [ND-1:0] latest_dp = '0, shown_dp = '0;

    seven_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scan #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .GUARD      (GD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Glyph described by its lit segment letters, converted to active-low GFEDCBA.
    function automatic logic [6:0] glyph(input logic [3:0] h);
        string      s;
        logic [6:0] lit;
        lit = '0;
        case (h)
            4'h0: s = "abcdef";   4'h1: s = "bc";
            4'h2: s = "abdeg";    4'h3: s = "abcdg";
            4'h4: s = "bcfg";     4'h5: s = "acdfg";
            4'h6: s = "acdefg";   4'h7: s = "abc";
            4'h8: s = "abcdefg";  4'h9: s = "abcdfg";
            4'hA: s = "abcefg";   4'hB: s = "cdefg";
            4'hC: s = "adef";     4'hD: s = "bcdeg";
            4'hE: s = "adefg";    default: s = "aefg";
        endcase
        for (int k = 0; k < s.len(); k++) lit[int'(s[k]) - 97] = 1'b1;
        return ~lit;
    endfunction

    function automatic logic lz_blank(input logic [15:0] v, input logic [ND-1:0] dp, input int d);
`ifdef SEVSEG_LZB_EN
        if (d == 0) return 1'b0;
        for (int j = d; j < ND; j++) begin
            if (v[j*4 +: 4] != 4'h0 || dp[j]) return 1'b0;
        end
        return 1'b1;
`else
        return (v[0] & dp[0] & 1'b0) | (d < 0);
`endif
    endfunction

    // Reference model: n edges since reset release selects slot, digit and phase.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            t = 0;
            latest_v = '0; latest_dp = '0;
            shown_v  = '0; shown_dp  = '0;
            exp_q.delete();
        end else begin
            exp_t        e;
            int          phase, digit;
            logic        bnd;
            logic [ND-1:0] one;
            one   = 1;
            phase = t % SD;
            digit = (t / SD) % ND;
            bnd   = (t % FRAME) == FRAME - 1;
            e.n   = t;
            e.fd  = bnd;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            e.an  = '1;
            if (phase >= GD && !bus.blank && !lz_blank(shown_v, shown_dp, digit)) begin
                e.an  = ~(one << digit);
                e.seg = glyph(shown_v[digit*4 +: 4]);
                e.dp  = ~shown_dp[digit];
            end
            exp_q.push_back(e);
            if (bus.load) begin
                latest_v  = bus.value;
                latest_dp = bus.dp_mask;
            end
            if (bnd) begin
                shown_v  = latest_v;
                shown_dp = latest_dp;
            end
            t++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.seg_n !== e.seg || bus.dp_n !== e.dp || bus.an_n !== e.an || bus.frame_done !== e.fd) begin
                errors++;
                $display("FAIL pins n=%0d got seg=%b dp=%b an=%b fd=%b expected seg=%b dp=%b an=%b fd=%b",
                         e.n, bus.seg_n, bus.dp_n, bus.an_n, bus.frame_done, e.seg, e.dp, e.an, e.fd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_pins(input string name);
        checks++;
        if (bus.seg_n !== 7'h7F || bus.dp_n !== 1'b1 || bus.an_n !== {ND{1'b1}} || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s got seg=%b dp=%b an=%b fd=%b expected seg=1111111 dp=1 an=1111 fd=0",
                     name, bus.seg_n, bus.dp_n, bus.an_n, bus.frame_done);
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        check_reset_pins(name);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [ND-1:0] dp);
        bus.value   = v;
        bus.dp_mask = dp;
        bus.load    = 1'b1;
        tick();
        bus.load    = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (t % FRAME == p) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_phase timeout got t=%0d expected phase %0d", t, p);
    endtask

    initial begin
        bus.load    = 1'b0;
        bus.value   = '0;
        bus.dp_mask = '0;
        bus.blank   = 1'b0;
        #2;
        do_reset("reset_initial");
        repeat (40) tick();

        wait_phase(10);
        do_load(16'h12AF, 4'b0100);
        repeat (70) tick();

        wait_phase(5);
        do_load(16'h1111, 4'b0000);
        wait_phase(20);
        do_load(16'h2222, 4'b0000);
        repeat (70) tick();

        wait_phase(FRAME - 1);
        do_load(16'h3C5E, 4'b0001);
        repeat (40) tick();

        wait_phase(0);
        bus.blank = 1'b1;
        repeat (FRAME + 8) tick();
        bus.blank = 1'b0;

        do_load(16'h0050, 4'b0000);
        repeat (70) tick();

        wait_phase(5);
        do_load(16'hBEEF, 4'b1010);
        repeat (3) tick();
        #2;
        do_reset("reset_mid_frame");
        repeat (70) tick();

        for (int it = 0; it < 14; it++) begin
            logic [15:0]   v;
            logic [ND-1:0] d;
            int            w;
            v = 16'($urandom);
            if (it % 3 == 0) v = v & 16'h00FF;
            if (it % 3 == 1) v = v & 16'h000F;
            d = ND'($urandom_range(0, 3) == 0 ? $urandom : 0);
            w = $urandom_range(0, 40);
            for (int k = 0; k < w; k++) begin
                bus.blank = ($urandom_range(0, 7) == 0);
                tick();
            end
            bus.blank = 1'b0;
            do_load(v, d);
        end
        repeat (70) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
